// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//
// Turns the SPI-written configuration registers into 16 driven outputs. Each
// output is forced off, forced on, or follows one shared 8-bit PWM waveform.
// A prescaler (CLK_DIV clocks per count step) feeds an 8-bit free-running
// period counter. Each PWM period is therefore 256 * CLK_DIV clocks long.
//
// Optional feature (build macro PWM_DUTY_SHADOW_EN):
//   defined   : the duty value is captured into a shadow register on the
//               255->0 wrap. A mid-period write then waits for the next
//               period, so the output never produces a runt pulse.
//   undefined : the duty value is used directly, and a change shows up on
//               `out` one cycle later.
//
// Parameters
//   CLK_DIV          system clocks per PWM count step, 1..65535
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous, active-high reset
//   en_reg_out_7_0   output enable, outputs 7..0
//   en_reg_out_15_8  output enable, outputs 15..8
//   en_reg_pwm_7_0   PWM mode select, outputs 7..0
//   en_reg_pwm_15_8  PWM mode select, outputs 15..8
//   pwm_duty_cycle   duty value shared by every PWM-mode output
//   out              registered outputs
//   period_start     registered one-cycle pulse on the first count-0 cycle
//                    after each wrap
// -----------------------------------------------------------------------------
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  // $clog2(1) is 0, so the counter is kept at least one bit wide.
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       pwm_cnt;
  logic             tick;
  logic             wrap;
  logic [7:0]       duty_active;
  logic             pwm_level;
  logic [15:0]      out_next;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // With CLK_DIV = 1 the counter sits at 0 == DIV_LAST, so tick is constant.
  assign tick = (div_cnt == DIV_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // Prescaler and period counter.
  // NOTE: the reset is synchronous, so it is tested inside the clocked block
  // and is not in the sensitivity list. Its branch comes first, so it takes
  // priority over every other update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pwm_cnt <= 8'h00;
    end else begin
      // NOTE: state registers use non-blocking assignments. Every flop then
      // samples the pre-edge values, whatever order the statements are in.
      if (tick) begin
        div_cnt <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;   // 255 -> 0 wraps with no hold state
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_shadow;

  // The shadow loads on the same edge that wraps pwm_cnt to 0. The new
  // duty then covers the whole of the next period, starting at count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow <= 8'h00;
    end else if (wrap) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  assign duty_active = duty_shadow;
`else
  assign duty_active = pwm_duty_cycle;
`endif

  // 0xFF is special-cased to a constant 1. Without it, the counter would
  // reach 255 and give a single low count per period.
  always_comb begin
    // NOTE: every combinational output gets a value before any branching,
    // so no path through the block can infer a latch.
    pwm_level = 1'b0;
    out_next  = 16'h0000;
    if (duty_active == 8'hFF) begin
      pwm_level = 1'b1;
    end else begin
      pwm_level = (pwm_cnt < duty_active);
    end
    // Enabled static outputs are 1, enabled PWM outputs follow the level,
    // and disabled outputs are 0.
    out_next = en_out & (~en_pwm | {16{pwm_level}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= 16'h0000;
      period_start <= 1'b0;
    end else begin
      out          <= out_next;
      // Registered from the wrap, so the pulse lands on the first count-0
      // cycle of the new period. It never fires on reset release.
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//
// Runs four pwm_peripheral instances (CLK_DIV = 1, 2, 4, 13) from one set of
// stimulus. A time-based reference model predicts out and period_start for
// every cycle. It counts cycles since reset release, derives the count value
// and period boundaries by division, and applies the output rules per bit.
// Directed phases add aggregate checks on window lengths and high-cycle
// counts between period_start pulses. A randomized phase follows them.
// Build macro PWM_DUTY_SHADOW_EN selects the shadowed-duty expectations.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

`ifdef PWM_DUTY_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  localparam int NDUT = 4;

  function automatic int div_of(input int idx);
    case (idx)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 13;
    endcase
  endfunction

  logic        clk;
  logic        rst;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] dut_out [NDUT];
  logic        dut_ps  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pwm_peripheral #(.CLK_DIV(div_of(g))) u_dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (dut_out[g]),
      .period_start    (dut_ps[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state per instance: cycle index since reset release and duty shadow.
  int         mt  [NDUT];
  logic [7:0] msh [NDUT];
  int         cyc = 0;

  // Window tracker: it watches one instance. For each span between
  // consecutive period_start pulses it records the length in cycles and
  // the number of cycles with out[0] high.
  int trk      = 0;
  int trk_last = -1;
  int trk_hi   = 0;
  int iq[$];
  int hq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rule_out(input logic [15:0] eo, input logic [15:0] ep,
                                           input logic lvl);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      if (!eo[b])      r[b] = 1'b0;
      else if (!ep[b]) r[b] = 1'b1;
      else             r[b] = lvl;
    end
    return r;
  endfunction

  task automatic track(input int idx);
    trk      = idx;
    trk_last = -1;
    trk_hi   = 0;
    iq.delete();
    hq.delete();
  endtask

  // Predicts the outputs for the coming edge from the current inputs. It
  // then advances one clock and compares the outputs of every instance.
  task automatic step();
    logic [15:0] exp_o [NDUT];
    logic        exp_p [NDUT];
    logic [15:0] eo, ep;
    int          p, cnt;
    logic [7:0]  duty;
    logic        lvl;
    eo = {en_reg_out_15_8, en_reg_out_7_0};
    ep = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        exp_o[i] = 16'h0000;
        exp_p[i] = 1'b0;
        mt[i]    = 0;
        msh[i]   = 8'h00;
      end else begin
        p        = 256 * div_of(i);
        cnt      = (mt[i] / div_of(i)) % 256;
        duty     = SHADOW ? msh[i] : pwm_duty_cycle;
        lvl      = (duty == 8'hFF) || (cnt < int'(duty));
        exp_o[i] = rule_out(eo, ep, lvl);
        exp_p[i] = ((mt[i] + 1) % p) == 0;
        if ((mt[i] % p) == p - 1) msh[i] = pwm_duty_cycle;
        mt[i]    = mt[i] + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("out_div%0d_cyc%0d", div_of(i), cyc), 32'(dut_out[i]), 32'(exp_o[i]));
      check($sformatf("ps_div%0d_cyc%0d", div_of(i), cyc), 32'(dut_ps[i]), 32'(exp_p[i]));
    end
    if (dut_ps[trk] === 1'b1) begin
      if (trk_last >= 0) begin
        iq.push_back(cyc - trk_last);
        hq.push_back(trk_hi);
      end
      trk_last = cyc;
      trk_hi   = 0;
    end
    if (dut_out[trk][0] === 1'b1) trk_hi++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  initial begin
    int gap;
    int hold;

    for (int i = 0; i < NDUT; i++) begin
      mt[i]  = 0;
      msh[i] = 8'h00;
    end

    // Reset held 3 cycles with everything enabled and duty 0x80.
    rst = 1'b1;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h80;
    run(3);
    check("rst_out", 32'(dut_out[3]), 32'h0);
    rst = 1'b0;
    step();
    check("release_out", 32'(dut_out[0]), SHADOW ? 32'h0 : 32'hFFFF);

    // Static mode: outputs 15 and 0 forced on, then everything disabled.
    set_en(16'h8001, 16'h0000);
    step();
    check("static_on", 32'(dut_out[2]), 32'h8001);
    run(2100);
    check("static_hold", 32'(dut_out[2]), 32'h8001);
    set_en(16'h0000, 16'h0000);
    step();
    check("static_off", 32'(dut_out[2]), 32'h0);
    run(4);

    // Duty ratio on CLK_DIV = 2: 512-cycle windows, 256 cycles high each.
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h80;
    track(1);
    run(5 * 512);
    check("ratio_windows", 32'(iq.size() >= 3), 32'h1);
    for (int w = 1; w < iq.size(); w++) begin
      check($sformatf("ratio_len_w%0d", w), 32'(iq[w]), 32'd512);
      check($sformatf("ratio_hi_w%0d", w), 32'(hq[w]), 32'd256);
    end

    // Duty endpoints: 0x00 is never high, 0xFF is never low.
    pwm_duty_cycle = 8'h00;
    track(1);
    run(4 * 512);
    check("duty00_windows", 32'(hq.size() >= 2), 32'h1);
    for (int w = 1; w < hq.size(); w++)
      check($sformatf("duty00_hi_w%0d", w), 32'(hq[w]), 32'd0);
    pwm_duty_cycle = 8'hFF;
    track(1);
    run(4 * 512);
    check("dutyFF_windows", 32'(hq.size() >= 2), 32'h1);
    for (int w = 1; w < hq.size(); w++)
      check($sformatf("dutyFF_hi_w%0d", w), 32'(hq[w]), 32'd512);

    // Mid-period update on CLK_DIV = 1: duty 0x40 -> 0xC0 at count 0x20.
    pwm_duty_cycle = 8'h40;
    run(600);
    for (int n = 0; n < 300 && (mt[0] % 256) != 'h80; n++) step();
    track(0);
    for (int n = 0; n < 300 && (mt[0] % 256) != 'h20; n++) step();
    pwm_duty_cycle = 8'hC0;
    run(600);
    check("midupd_windows", 32'(hq.size() >= 2), 32'h1);
    if (hq.size() >= 2) begin
      check("midupd_cur_hi", 32'(hq[0]), SHADOW ? 32'd64 : 32'd192);
      check("midupd_next_hi", 32'(hq[1]), 32'd192);
    end

    // Mid-operation reset on CLK_DIV = 4 at count 0x77.
    for (int n = 0; n < 1100 && ((mt[2] / 4) % 256) != 'h77; n++) step();
    check("pre_rst_out", 32'(dut_out[2]), 32'hFFFF);
    rst = 1'b1;
    step();
    check("mid_rst_out", 32'(dut_out[2]), 32'h0);
    rst = 1'b0;
    gap = -1;
    for (int n = 1; n <= 1100; n++) begin
      step();
      if (dut_ps[2] === 1'b1) begin
        gap = n;
        break;
      end
    end
    check("mid_rst_gap", 32'(gap), 32'd1024);

    // Randomized enables, duty and occasional one-cycle resets.
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        set_en(16'($urandom), 16'($urandom));
        case ($urandom_range(0, 3))
          0:       pwm_duty_cycle = 8'h00;
          1:       pwm_duty_cycle = 8'hFF;
          default: pwm_duty_cycle = 8'($urandom);
        endcase
        hold = $urandom_range(1, 60);
      end
      hold--;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
